// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the four-cache data-memory arbiter: FSM encoding,
// default widths and port index constants.
package cache_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  localparam logic [1:0] PORT1 = 2'd0;
  localparam logic [1:0] PORT2 = 2'd1;
  localparam logic [1:0] PORT3 = 2'd2;
  localparam logic [1:0] PORT4 = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/cache_mem_arbiter_rr_arbiter4.sv
// Four-way round-robin picker: the first requester after last_grant_i,
// wrapping cyclically, wins. Purely combinational.
module rr_arbiter4 (
  input  logic [3:0] req_i,
  input  logic [1:0] last_grant_i,
  output logic [1:0] grant_o,
  output logic       valid_o
);

  logic [1:0] idx;

  // Scan from lowest priority (last_grant itself) to highest so the nearest
  // requester after last_grant overwrites everything before it.
  always_comb begin
    grant_o = last_grant_i;
    valid_o = 1'b0;
    idx     = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = last_grant_i + 2'(k);
      if (req_i[idx]) begin
        grant_o = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Memory-side responder for four data caches: round-robin arbitration of
// refill reads and write-backs onto a single data memory, one at a time.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              c1_mem_read,
  input  logic              c1_mem_write,
  input  logic [ADDR_W-1:0] c1_mem_address,
  input  logic [DATA_W-1:0] c1_mem_writedata,
  output logic [DATA_W-1:0] c1_mem_readdata,
  output logic              c1_mem_busywait,
  input  logic              c2_mem_read,
  input  logic              c2_mem_write,
  input  logic [ADDR_W-1:0] c2_mem_address,
  input  logic [DATA_W-1:0] c2_mem_writedata,
  output logic [DATA_W-1:0] c2_mem_readdata,
  output logic              c2_mem_busywait,
  input  logic              c3_mem_read,
  input  logic              c3_mem_write,
  input  logic [ADDR_W-1:0] c3_mem_address,
  input  logic [DATA_W-1:0] c3_mem_writedata,
  output logic [DATA_W-1:0] c3_mem_readdata,
  output logic              c3_mem_busywait,
  input  logic              c4_mem_read,
  input  logic              c4_mem_write,
  input  logic [ADDR_W-1:0] c4_mem_address,
  input  logic [DATA_W-1:0] c4_mem_writedata,
  output logic [DATA_W-1:0] c4_mem_readdata,
  output logic              c4_mem_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  state_e            state_q;
  logic [1:0]        grant_q;
  logic [1:0]        last_grant_q;
  logic              is_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_read_q;
  logic              mem_write_q;

  logic [3:0]        req;
  logic [3:0]        wr_req;
  logic [1:0]        arb_grant;
  logic              arb_valid;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic              done_c;

  assign wr_req = {c4_mem_write, c3_mem_write, c2_mem_write, c1_mem_write};
  assign req    = wr_req | {c4_mem_read, c3_mem_read, c2_mem_read, c1_mem_read};

  rr_arbiter4 u_rr (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .valid_o      (arb_valid)
  );

  always_comb begin
    addr_sel  = c1_mem_address;
    wdata_sel = c1_mem_writedata;
    case (arb_grant)
      PORT2: begin
        addr_sel  = c2_mem_address;
        wdata_sel = c2_mem_writedata;
      end
      PORT3: begin
        addr_sel  = c3_mem_address;
        wdata_sel = c3_mem_writedata;
      end
      PORT4: begin
        addr_sel  = c4_mem_address;
        wdata_sel = c4_mem_writedata;
      end
      default: ;
    endcase
  end

  // Combinational so a fresh request stalls in its very first cycle.
  assign done_c          = (state_q == DONE);
  assign c1_mem_busywait = req[0] & ~(done_c & (grant_q == PORT1));
  assign c2_mem_busywait = req[1] & ~(done_c & (grant_q == PORT2));
  assign c3_mem_busywait = req[2] & ~(done_c & (grant_q == PORT3));
  assign c4_mem_busywait = req[3] & ~(done_c & (grant_q == PORT4));

  assign c1_mem_readdata = rdata_q;
  assign c2_mem_readdata = rdata_q;
  assign c3_mem_readdata = rdata_q;
  assign c4_mem_readdata = rdata_q;

  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = addr_q;
  assign mem_writedata = wdata_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= PORT1;
      last_grant_q <= PORT4;
      is_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            // Write wins when a cache (illegally) raises both strobes.
            grant_q     <= arb_grant;
            addr_q      <= addr_sel;
            wdata_q     <= wdata_sel;
            is_write_q  <= wr_req[arb_grant];
            mem_read_q  <= ~wr_req[arb_grant];
            mem_write_q <= wr_req[arb_grant];
            state_q     <= ISSUE;
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (!mem_busywait) begin
            if (!is_write_q) rdata_q <= mem_readdata;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          last_grant_q <= grant_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: four cache drivers, a data memory
// model, and a transaction-level reference for grant order and data.
module tb_cache_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  typedef struct {
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [3:0]    rd, wr;
  logic [AW-1:0] addr [4];
  logic [DW-1:0] wdat [4];
  wire  [DW-1:0] rdat [4];
  wire  [3:0]    bw;
  wire           mem_read, mem_write;
  wire  [AW-1:0] mem_address;
  wire  [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata = '0;
  logic          mem_busywait;

  int checks = 0;
  int failures = 0;

  req_t          req_q  [4][$];
  logic [DW:0]   resp_q [4][$];
  int            served_q [$];
  int            waits [4];
  int            ref_last = 3;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] mem_arr [logic [AW-1:0]];
  logic [3:0]    req_prev1 = 4'b0, req_prev2 = 4'b0;
  int            mstate, rem, fixed_lat;

  cache_mem_arbiter dut (
    .clock(clock), .reset(reset),
    .c1_mem_read(rd[0]), .c1_mem_write(wr[0]), .c1_mem_address(addr[0]),
    .c1_mem_writedata(wdat[0]), .c1_mem_readdata(rdat[0]), .c1_mem_busywait(bw[0]),
    .c2_mem_read(rd[1]), .c2_mem_write(wr[1]), .c2_mem_address(addr[1]),
    .c2_mem_writedata(wdat[1]), .c2_mem_readdata(rdat[1]), .c2_mem_busywait(bw[1]),
    .c3_mem_read(rd[2]), .c3_mem_write(wr[2]), .c3_mem_address(addr[2]),
    .c3_mem_writedata(wdat[2]), .c3_mem_readdata(rdat[2]), .c3_mem_busywait(bw[2]),
    .c4_mem_read(rd[3]), .c4_mem_write(wr[3]), .c4_mem_address(addr[3]),
    .c4_mem_writedata(wdat[3]), .c4_mem_readdata(rdat[3]), .c4_mem_busywait(bw[3]),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait)
  );

  always #5 clock = ~clock;

  task automatic chk_eq(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_blk(input logic [AW-1:0] a);
    return {4{{4'h0, a} ^ 32'h5A5A_0000}};
  endfunction

  function automatic int rr(input logic [3:0] req, input int last);
    for (int k = 1; k <= 4; k++) if (req[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  // Reference: at each memory access, predict the winner from the requests
  // seen in the IDLE cycle two cycles earlier, check the access, queue the reply.
  task automatic mem_accept();
    int p;
    req_t e;
    p = rr(req_prev2, ref_last);
    if (p < 0) begin chk_eq("grant_has_requester", 0, 1); return; end
    if (req_q[p].size() == 0) begin chk_eq($sformatf("pending_req_p%0d", p + 1), 0, 1); return; end
    e = req_q[p].pop_front();
    chk_eq($sformatf("mem_write_p%0d", p + 1), mem_write, e.w);
    chk_eq($sformatf("mem_read_p%0d", p + 1), mem_read, !e.w);
    chk_eq($sformatf("mem_address_p%0d", p + 1), mem_address, e.a);
    if (e.w) chk_eq($sformatf("mem_writedata_p%0d", p + 1), mem_writedata, e.d);
    chk_eq($sformatf("fairness_p%0d", p + 1), waits[p] <= 3, 1);
    for (int q = 0; q < 4; q++) if (q != p && (rd[q] | wr[q])) waits[q]++;
    served_q.push_back(p);
    ref_last = p;
    if (e.w) begin
      ref_mem[e.a] = e.d;
      resp_q[p].push_back({1'b1, e.d});
    end else begin
      resp_q[p].push_back({1'b0, ref_mem.exists(e.a) ? ref_mem[e.a] : init_blk(e.a)});
    end
  endtask

  always @(negedge clock) begin
    req_prev2 <= req_prev1;
    req_prev1 <= rd | wr;
  end

  always @(posedge reset) begin
    ref_last = 3;
    for (int p = 0; p < 4; p++) resp_q[p].delete();
  end

  // Data memory model: busy for fixed_lat (or random 2..6) WAIT cycles.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mstate       <= 0;
      mem_busywait <= 1'b0;
    end else begin
      case (mstate)
        0: if (mem_read | mem_write) begin
          mem_busywait <= 1'b1;
          mstate       <= 1;
          rem          <= (fixed_lat != 0) ? fixed_lat : int'($urandom_range(6, 2));
          mem_accept();
        end
        1: begin
          rem <= rem - 1;
          if (rem == 2) begin
            chk_eq("mem_req_held", mem_read | mem_write, 1);
            mem_busywait <= 1'b0;
            mstate       <= 2;
            if (mem_write) mem_arr[mem_address] = mem_writedata;
            else mem_readdata <= mem_arr.exists(mem_address) ? mem_arr[mem_address] : init_blk(mem_address);
          end
        end
        default: mstate <= 0;
      endcase
    end
  end

  // Release monitor: a requesting port with busywait low has been answered.
  int nrel;
  logic [DW:0] rsp;
  always @(negedge clock) begin
    if (!reset) begin
      nrel = 0;
      for (int p = 0; p < 4; p++) begin
        if ((rd[p] | wr[p]) && !bw[p]) begin
          nrel++;
          chk_eq("done_mem_strobes_low", {mem_read, mem_write}, 0);
          if (resp_q[p].size() == 0) chk_eq($sformatf("expected_release_p%0d", p + 1), 0, 1);
          else begin
            rsp = resp_q[p].pop_front();
            if (!rsp[DW]) chk_eq($sformatf("readdata_p%0d", p + 1), rdat[p], rsp[DW-1:0]);
          end
        end
      end
      if (nrel > 0) chk_eq("single_release", nrel > 1, 0);
    end
  end

  task automatic wait_rel(input int p, output int cyc);
    cyc = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!bw[p]) break;
      if (cyc > 400) begin chk_eq($sformatf("release_timeout_p%0d", p + 1), 0, 1); break; end
    end
    @(posedge clock); #1;
    rd[p] = 1'b0;
    wr[p] = 1'b0;
  endtask

  task automatic txn(input int p, input bit r, input bit w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, output int cyc);
    req_t e;
    e.w = w; e.a = a; e.d = d;
    req_q[p].push_back(e);
    waits[p] = 0;
    addr[p] = a; wdat[p] = d; rd[p] = r; wr[p] = w;
    wait_rel(p, cyc);
  endtask

  task automatic rand_port(input int p);
    int c;
    bit w;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(2, 0)) begin @(posedge clock); #1; end
      w = 1'($urandom_range(1, 0));
      txn(p, !w, w, AW'($urandom_range(15, 0)), {$urandom, $urandom, $urandom, $urandom}, c);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int cyc;
  req_t er;
  initial begin
    reset = 1'b1; rd = 4'b0; wr = 4'b0; fixed_lat = 0;
    for (int p = 0; p < 4; p++) begin addr[p] = '0; wdat[p] = '0; waits[p] = 0; end
    repeat (3) @(posedge clock);
    #1;
    chk_eq("reset_mem_read", mem_read, 0);
    chk_eq("reset_mem_write", mem_write, 0);
    chk_eq("reset_mem_address", mem_address, 0);
    chk_eq("reset_mem_writedata", mem_writedata, 0);
    chk_eq("reset_busywait_idle", bw, 0);
    for (int p = 0; p < 4; p++) chk_eq($sformatf("reset_readdata_p%0d", p + 1), rdat[p], 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Single read, five WAIT cycles -> eight cycles to release.
    mem_arr[28'h10] = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    ref_mem[28'h10] = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    fixed_lat = 5;
    txn(0, 1'b1, 1'b0, 28'h10, '0, cyc);
    chk_eq("read_latency", cyc, 8);

    // Single write from c3, read back from c1.
    txn(2, 1'b0, 1'b1, 28'hFF, {32{4'h1}}, cyc);
    chk_eq("write_latency", cyc, 8);
    txn(0, 1'b1, 1'b0, 28'hFF, '0, cyc);

    // Read and write together: treated as a write.
    fixed_lat = 0;
    txn(0, 1'b1, 1'b1, 28'h20, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, cyc);
    txn(1, 1'b1, 1'b0, 28'h20, '0, cyc);

    // Contention right after reset: order 1,2,3,4.
    pulse_reset();
    served_q.delete();
    fork
      txn(0, 1'b1, 1'b0, 28'h31, '0, cyc);
      txn(1, 1'b1, 1'b0, 28'h32, '0, cyc);
      txn(2, 1'b1, 1'b0, 28'h33, '0, cyc);
      txn(3, 1'b1, 1'b0, 28'h34, '0, cyc);
    join
    chk_eq("contention_count", served_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk_eq($sformatf("contention_order_%0d", i), (served_q.size() > i) ? served_q[i] : -1, i);

    // Round-robin: after c3 is served, c4 beats c2.
    served_q.delete();
    txn(2, 1'b1, 1'b0, 28'h40, '0, cyc);
    fork
      txn(1, 1'b1, 1'b0, 28'h41, '0, cyc);
      txn(3, 1'b1, 1'b0, 28'h42, '0, cyc);
    join
    chk_eq("rr_first_after_c3", (served_q.size() > 1) ? served_q[1] : -1, 3);
    chk_eq("rr_second_after_c3", (served_q.size() > 2) ? served_q[2] : -1, 1);

    // Reset in the middle of a c2 read.
    fixed_lat = 6;
    er.w = 1'b0; er.a = 28'h44; er.d = '0;
    req_q[1].push_back(er);
    waits[1] = 0;
    addr[1] = 28'h44; rd[1] = 1'b1;
    cyc = 0;
    while (!mem_busywait && cyc < 50) begin @(negedge clock); cyc++; end
    chk_eq("midwait_busy_seen", mem_busywait, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk_eq("midreset_mem_read", mem_read, 0);
    chk_eq("midreset_mem_address", mem_address, 0);
    chk_eq("midreset_readdata", rdat[1], 0);
    chk_eq("midreset_busywait_c2", bw[1], 1);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int p = 0; p < 4; p++) req_q[p].delete();
    req_q[1].push_back(er);
    served_q.delete();
    wait_rel(1, cyc);
    chk_eq("post_reset_grant_c2", (served_q.size() > 0) ? served_q[0] : -1, 1);
    chk_eq("post_reset_latency", cyc, 9);

    // Randomized traffic on all four ports.
    fixed_lat = 0;
    fork
      rand_port(0);
      rand_port(1);
      rand_port(2);
      rand_port(3);
    join
    repeat (4) @(posedge clock);
    for (int p = 0; p < 4; p++) chk_eq($sformatf("drained_p%0d", p + 1), resp_q[p].size() + req_q[p].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
